// File: rtl/sprite_pixel_fetch_pkg.sv
// sprite_pkg: shared types and constants for the sprite pixel fetch block.
//   anim_state_t    : animation controller state (IDLE, PLAY, DONE)
//   pal_idx_t       : 4-bit palette index
//   TRANSPARENT_IDX : index value treated as "no pixel"
//   SCREEN_W_BITS   : width of beam / sprite coordinates
//   frame_w()       : width of the frame counter, at least 1 bit
package sprite_pkg;

  localparam int SCREEN_W_BITS = 10;

  typedef logic [3:0] pal_idx_t;

  localparam pal_idx_t TRANSPARENT_IDX = 4'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    DONE = 2'd2
  } anim_state_t;

  function automatic int frame_w(input int num_frames);
    return (num_frames > 1) ? $clog2(num_frames) : 1;
  endfunction

endpackage

// File: rtl/sprite_pixel_fetch_if.sv
// sprite_pixel_fetch_if: animation control/status bundle between the pixel
// pipeline (master) and the animation controller (slave).
//   frame_tick, start, loop : controls, master -> slave
//   anim_frame, busy, anim_done, state : status, slave -> master
// Handshake: no valid/ready; start and frame_tick are single-cycle pulses
// sampled on the rising clock edge, status is valid every cycle.
interface sprite_pixel_fetch_if
  import sprite_pkg::*;
#(
  parameter int FRM_W = 2
);
  logic             frame_tick;
  logic             start;
  logic             loop;
  logic [FRM_W-1:0] anim_frame;
  logic             busy;
  logic             anim_done;
  anim_state_t      state;

  modport master (
    output frame_tick, start, loop,
    input  anim_frame, busy, anim_done, state
  );

  modport slave (
    input  frame_tick, start, loop,
    output anim_frame, busy, anim_done, state
  );
endinterface

// File: rtl/sprite_pixel_fetch_anim_ctrl.sv
// sprite_anim_ctrl: animation frame counter with one-shot / looping playback.
//   clk, rst_n : clock, synchronous active-low reset
//   ctl        : slave side of sprite_pixel_fetch_if
// FRAME_DIV ticks make one animation frame. A one-shot ends in DONE for one
// cycle (anim_done pulse, last frame still shown) and then returns to IDLE.
// start always restarts at frame 0 and takes priority over a same-cycle tick.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sprite_pixel_fetch_if.slave  ctl
);
  localparam int FRM_W = frame_w(NUM_FRAMES);
  localparam int DIV_W = $clog2(FRAME_DIV + 1);

  anim_state_t      state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [FRM_W-1:0] frame_q, frame_d;

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    frame_d = frame_q;
    if (ctl.start) begin
      state_d = PLAY;
      div_d   = '0;
      frame_d = '0;
    end else begin
      case (state_q)
        PLAY: begin
          if (ctl.frame_tick) begin
            if (div_q == DIV_W'(FRAME_DIV - 1)) begin
              div_d = '0;
              if (frame_q == FRM_W'(NUM_FRAMES - 1)) begin
                if (ctl.loop) frame_d = '0;
                else          state_d = DONE;  // last frame held through DONE
              end else begin
                frame_d = frame_q + FRM_W'(1);
              end
            end else begin
              div_d = div_q + DIV_W'(1);
            end
          end
        end
        DONE: begin
          state_d = IDLE;
          div_d   = '0;
          frame_d = '0;
        end
        default: begin
          state_d = IDLE;
          div_d   = '0;
          frame_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      frame_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      frame_q <= frame_d;
    end
  end

  assign ctl.anim_frame = frame_q;
  assign ctl.busy       = (state_q == PLAY);
  assign ctl.anim_done  = (state_q == DONE);
  assign ctl.state      = state_q;

endmodule

// File: rtl/sprite_pixel_fetch.sv
// sprite_pixel_fetch: maps the beam position onto a sprite bounding box,
// addresses the sprite index ROM and returns a palette index + hit flag
// two clocks after the pixel was sampled.
//   Clk, Reset_n                : clock, synchronous active-low reset
//   DrawX, DrawY, pix_en        : beam position and active-video qualifier
//   sprite_x, sprite_y, flip    : sprite placement and horizontal mirror
//   frame_tick, start, loop     : animation controls
//   rom_addr / rom_data         : index ROM (1-clock registered read)
//   pal_index, pix_hit          : result to palette stage
//   anim_frame, busy, anim_done : animation status
//   dbg_state                   : animation controller state (debug)
// Optional: define SPRITE_SCALE2X_EN to draw each texel as a 2x2 block.
module sprite_pixel_fetch
  import sprite_pkg::*;
#(
  parameter int SPR_W      = 64,
  parameter int SPR_H      = 96,
  parameter int NUM_FRAMES = 4,
  parameter int FRAME_DIV  = 6,
  parameter int ADDR_W     = 15
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [SCREEN_W_BITS-1:0]      DrawX,
  input  logic [SCREEN_W_BITS-1:0]      DrawY,
  input  logic                          pix_en,
  input  logic [SCREEN_W_BITS-1:0]      sprite_x,
  input  logic [SCREEN_W_BITS-1:0]      sprite_y,
  input  logic                          flip,
  input  logic                          frame_tick,
  input  logic                          start,
  input  logic                          loop,
  output logic [ADDR_W-1:0]             rom_addr,
  input  pal_idx_t                      rom_data,
  output pal_idx_t                      pal_index,
  output logic                          pix_hit,
  output logic [frame_w(NUM_FRAMES)-1:0] anim_frame,
  output logic                          busy,
  output logic                          anim_done,
  output anim_state_t                   dbg_state
);
  localparam int FRM_W = frame_w(NUM_FRAMES);
  localparam int CW    = SCREEN_W_BITS + 1;
`ifdef SPRITE_SCALE2X_EN
  localparam int BOX_W = 2 * SPR_W;
  localparam int BOX_H = 2 * SPR_H;
`else
  localparam int BOX_W = SPR_W;
  localparam int BOX_H = SPR_H;
`endif

  sprite_pixel_fetch_if #(.FRM_W(FRM_W)) anim_if ();

  assign anim_if.frame_tick = frame_tick;
  assign anim_if.start      = start;
  assign anim_if.loop       = loop;

  sprite_anim_ctrl #(
    .NUM_FRAMES (NUM_FRAMES),
    .FRAME_DIV  (FRAME_DIV)
  ) u_anim (
    .clk   (Clk),
    .rst_n (Reset_n),
    .ctl   (anim_if.slave)
  );

  assign anim_frame = anim_if.anim_frame;
  assign busy       = anim_if.busy;
  assign anim_done  = anim_if.anim_done;
  assign dbg_state  = anim_if.state;

  logic [CW-1:0]     dx, dy, tx, ty, col;
  logic              in_box;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic              in_box_d1_q, in_box_d1_d;
  logic              in_box_d2_q, in_box_d2_d;

  always_comb begin
    // 11-bit differences: bit 10 set means the beam is left of / above the
    // sprite, which also rejects wrap-around at the right/bottom edges.
    dx     = {1'b0, DrawX} - {1'b0, sprite_x};
    dy     = {1'b0, DrawY} - {1'b0, sprite_y};
    in_box = pix_en & ~dx[CW-1] & ~dy[CW-1] &
             (dx < CW'(BOX_W)) & (dy < CW'(BOX_H));
`ifdef SPRITE_SCALE2X_EN
    tx = dx >> 1;
    ty = dy >> 1;
`else
    tx = dx;
    ty = dy;
`endif
    col  = flip ? (CW'(SPR_W - 1) - tx) : tx;
    addr = ADDR_W'(anim_if.anim_frame) * ADDR_W'(SPR_W * SPR_H)
         + ADDR_W'(ty) * ADDR_W'(SPR_W)
         + ADDR_W'(col);
    rom_addr_d  = in_box ? addr : '0;
    in_box_d1_d = in_box;
    in_box_d2_d = in_box_d1_q;  // lines up with rom_data from the ROM register
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rom_addr_q  <= '0;
      in_box_d1_q <= 1'b0;
      in_box_d2_q <= 1'b0;
    end else begin
      rom_addr_q  <= rom_addr_d;
      in_box_d1_q <= in_box_d1_d;
      in_box_d2_q <= in_box_d2_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign pal_index = in_box_d2_q ? rom_data : TRANSPARENT_IDX;
  assign pix_hit   = in_box_d2_q & (rom_data != TRANSPARENT_IDX);

endmodule

// File: tb/tb_sprite_pixel_fetch.sv
// Bench for sprite_pixel_fetch: random and directed stimulus compared every
// cycle against a tick-count / coordinate-arithmetic reference model, plus
// hand-computed expectations for the documented scenarios.
module tb_sprite_pixel_fetch;
  import sprite_pkg::*;

  localparam int SPR_W = 64;
  localparam int SPR_H = 96;
  localparam int NF    = 4;
  localparam int FD    = 6;
  localparam int AW    = 15;
`ifdef SPRITE_SCALE2X_EN
  localparam int SC = 2;
`else
  localparam int SC = 1;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [9:0]    draw_x = '0, draw_y = '0, spr_x = '0, spr_y = '0;
  logic          pix_en = 1'b0, flip = 1'b0, frame_tick = 1'b0, start = 1'b0, loop = 1'b0;
  logic [AW-1:0] rom_addr;
  pal_idx_t      rom_data;
  pal_idx_t      pal_index;
  logic          pix_hit, busy, anim_done;
  logic [1:0]    anim_frame;
  anim_state_t   dbg_state;

  sprite_pixel_fetch #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .NUM_FRAMES(NF), .FRAME_DIV(FD), .ADDR_W(AW)
  ) dut (
    .Clk(clk), .Reset_n(rst_n), .DrawX(draw_x), .DrawY(draw_y), .pix_en(pix_en),
    .sprite_x(spr_x), .sprite_y(spr_y), .flip(flip), .frame_tick(frame_tick),
    .start(start), .loop(loop), .rom_addr(rom_addr), .rom_data(rom_data),
    .pal_index(pal_index), .pix_hit(pix_hit), .anim_frame(anim_frame),
    .busy(busy), .anim_done(anim_done), .dbg_state(dbg_state)
  );

  // Index ROM with registered read.
  logic [3:0] rom_mem [0:(1<<AW)-1];
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model. Pixel side: each sampled pixel contributes {in_box, addr}
  // to exp_q; the entry sampled one edge earlier determines this edge's
  // palette output. Animation side: count ticks since start.
  logic [AW:0] exp_q[$];
  int m_ph = 0;    // 0 idle, 1 playing, 2 finished one-shot
  int m_n  = 0;    // ticks counted in the current cycle of playback
  int m_frame = 0;
  int e_addr = 0, e_pal = 0, e_frame = 0, e_busy = 0, e_done = 0;

  always @(posedge clk) begin
    int dx, dy, tx, ty, col, a;
    bit box;
    logic [AW:0] e;
    if (!rst_n) begin
      exp_q.delete();
      exp_q.push_back('0);
      e_addr = 0;
      e_pal  = 0;
      m_ph   = 0;
      m_n    = 0;
    end else begin
      e = exp_q.pop_front();
      e_pal = e[AW] ? int'(rom_mem[e[AW-1:0]]) : 0;
      dx  = int'(draw_x) - int'(spr_x);
      dy  = int'(draw_y) - int'(spr_y);
      box = pix_en && dx >= 0 && dy >= 0 && dx < SC*SPR_W && dy < SC*SPR_H;
      tx  = dx / SC;
      ty  = dy / SC;
      col = flip ? SPR_W - 1 - tx : tx;
      a   = box ? m_frame*SPR_W*SPR_H + ty*SPR_W + col : 0;
      e_addr = a;
      exp_q.push_back({box, AW'(a)});
      if (start) begin
        m_ph = 1; m_n = 0;
      end else if (m_ph == 1 && frame_tick) begin
        m_n++;
        if (m_n == FD*NF) begin
          if (loop) m_n = 0;
          else      m_ph = 2;
        end
      end else if (m_ph == 2) begin
        m_ph = 0; m_n = 0;
      end
    end
    m_frame = (m_ph == 1) ? m_n / FD : (m_ph == 2) ? NF - 1 : 0;
    e_frame = m_frame;
    e_busy  = (m_ph == 1);
    e_done  = (m_ph == 2);
  end

  // Compare process: every cycle, 2 time units after the rising edge.
  always @(posedge clk) begin
    #2;
    if (chk_en) begin
      check("rom_addr",   int'(rom_addr),   e_addr);
      check("pal_index",  int'(pal_index),  e_pal);
      check("pix_hit",    int'(pix_hit),    int'(e_pal != 0));
      check("anim_frame", int'(anim_frame), e_frame);
      check("busy",       int'(busy),       e_busy);
      check("anim_done",  int'(anim_done),  e_done);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic set_pix(input int x, input int y);
    @(negedge clk);
    draw_x = 10'(x);
    draw_y = 10'(y);
  endtask

  task automatic tick_once();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < (1<<AW); i++) rom_mem[i] = 4'($urandom_range(0, 15));

    rst_n = 1'b0;
    @(posedge clk);
    chk_en = 1'b1;
    cycles(3);
    check("reset_busy",  int'(busy), 0);
    check("reset_frame", int'(anim_frame), 0);
    check("reset_hit",   int'(pix_hit), 0);
    check("reset_addr",  int'(rom_addr), 0);
    rst_n = 1'b1;

    spr_x = 10'd100; spr_y = 10'd200; flip = 1'b0; pix_en = 1'b1;
`ifndef SPRITE_SCALE2X_EN
    // Plain lookup at (105,210), frame 0.
    rom_mem[645] = 4'd5;
    rom_mem[698] = 4'd9;
    set_pix(105, 210);
    @(negedge clk);
    check("t1_addr", int'(rom_addr), 645);
    @(negedge clk);
    check("t1_pal", int'(pal_index), 5);
    check("t1_hit", int'(pix_hit), 1);
    // Transparent texel.
    rom_mem[645] = 4'd0;
    @(negedge clk);
    check("t3_pal0", int'(pal_index), 0);
    check("t3_hit0", int'(pix_hit), 0);
    // Mirrored.
    flip = 1'b1;
    @(negedge clk);
    check("t2_addr_flip", int'(rom_addr), 698);
    @(negedge clk);
    check("t2_pal_flip", int'(pal_index), 9);
    check("t2_hit_flip", int'(pix_hit), 1);
    // Just outside left and right edges.
    draw_x = 10'd99;
    cycles(2);
    check("t2_left_hit", int'(pix_hit), 0);
    check("t2_left_pal", int'(pal_index), 0);
    draw_x = 10'd164;
    cycles(2);
    check("t2_right_hit", int'(pix_hit), 0);
    check("t2_right_pal", int'(pal_index), 0);
`endif

    // Random phase: placement, beam, flip and animation all randomized.
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if (i % 150 == 0) begin
        spr_x = 10'($urandom_range(0, 1023));
        spr_y = 10'($urandom_range(0, 1023));
        loop  = 1'($urandom_range(0, 1));
      end
      draw_x     = spr_x + 10'($urandom_range(0, SC*SPR_W + 20)) - 10'd10;
      draw_y     = spr_y + 10'($urandom_range(0, SC*SPR_H + 20)) - 10'd10;
      flip       = ($urandom_range(0, 15) == 0) ? ~flip : flip;
      pix_en     = ($urandom_range(0, 9) != 0);
      frame_tick = ($urandom_range(0, 9) < 4);
      start      = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    frame_tick = 1'b0; start = 1'b0;
    cycles(2);

    // One-shot: 24 ticks.
    loop = 1'b0;
    start_pulse();
    check("t4_busy_start", int'(busy), 1);
    for (int i = 1; i <= 24; i++) begin
      tick_once();
      if (i == 5)  check("t4_frame_t5",  int'(anim_frame), 0);
      if (i == 6)  check("t4_frame_t6",  int'(anim_frame), 1);
      if (i == 12) check("t4_frame_t12", int'(anim_frame), 2);
      if (i == 18) check("t4_frame_t18", int'(anim_frame), 3);
      if (i == 23) check("t4_done_t23",  int'(anim_done), 0);
    end
    check("t4_done",       int'(anim_done), 1);
    check("t4_busy_done",  int'(busy), 0);
    check("t4_frame_done", int'(anim_frame), 3);
    @(negedge clk);
    check("t4_done_clear", int'(anim_done), 0);
    check("t4_frame_idle", int'(anim_frame), 0);

    // Looping: 30 ticks, then start coincident with a tick.
    loop = 1'b1;
    start_pulse();
    for (int i = 1; i <= 30; i++) begin
      tick_once();
      if (i == 24) begin
        check("t5_frame_wrap", int'(anim_frame), 0);
        check("t5_busy_wrap",  int'(busy), 1);
      end
    end
    check("t5_frame_t30", int'(anim_frame), 1);
    @(negedge clk);
    start = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    start = 1'b0; frame_tick = 1'b0;
    check("t5_restart_frame", int'(anim_frame), 0);
    for (int i = 0; i < 5; i++) tick_once();
    check("t5_div_cleared", int'(anim_frame), 0);
    tick_once();
    check("t5_frame_after6", int'(anim_frame), 1);

    // Reset in the middle of playback at frame 2.
    loop = 1'b0;
    flip = 1'b0; pix_en = 1'b1; spr_x = 10'd100; spr_y = 10'd200;
    draw_x = 10'd105; draw_y = 10'd210;
    rom_mem[2*SPR_W*SPR_H + SC*0 + 645] = 4'd7;
    start_pulse();
    for (int i = 0; i < 12; i++) tick_once();
    check("t6_frame2", int'(anim_frame), 2);
    cycles(3);
`ifndef SPRITE_SCALE2X_EN
    check("t6_hit_before", int'(pix_hit), 1);
    check("t6_pal_before", int'(pal_index), 7);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    check("t6_frame_rst", int'(anim_frame), 0);
    check("t6_busy_rst",  int'(busy), 0);
    check("t6_hit_rst",   int'(pix_hit), 0);
    check("t6_done_rst",  int'(anim_done), 0);
    rst_n = 1'b1;
    cycles(4);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
